// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared configuration for the instruction fetch slice: default datapath
// width, instruction RAM placement and size, the fault substitute
// instruction, and the enable-level constants.
// Ports: none (package).
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int unsigned CFG_XLEN         = 32;
    localparam logic [31:0] CFG_BOOT_IT_ADDR = 32'h0000_0000;
    localparam int unsigned CFG_IT_RAM_DEPTH = 4096;
    localparam logic [31:0] CFG_NOP_INST     = 32'h0000_0013;

    // Enable levels for strobes driven toward the PC register and the RAM.
    localparam logic EN_ON  = 1'b1;
    localparam logic EN_OFF = 1'b0;

    // Width of a word index into an instruction RAM of depth_bytes bytes.
    function automatic int unsigned word_addr_bits(input int unsigned depth_bytes);
        return $clog2(depth_bytes / 4);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Bundles the fetch unit's three conversations: PC register (pc_addr,
// pc_en, redirect), instruction RAM read port (itram_rd_*) and the decode
// handshake (id_*).
// Modports:
//   master - the fetch unit (drives pc_en, itram_rd_en/addr, id_valid/inst/pc/fault)
//   slave  - its environment (drives pc_addr, redirect, itram_rd_data, id_ready)
// -----------------------------------------------------------------------------
interface inst_fetch_if
    import inst_fetch_pkg::*;
#(
    parameter int unsigned XLEN = CFG_XLEN,
    parameter int unsigned AW   = word_addr_bits(CFG_IT_RAM_DEPTH)
);

    logic [XLEN-1:0] pc_addr;
    logic            pc_en;
    logic            redirect;
    logic            itram_rd_en;
    logic [AW-1:0]   itram_rd_addr;
    logic [31:0]     itram_rd_data;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic            id_fault;

    modport master (
        input  pc_addr, redirect, itram_rd_data, id_ready,
        output pc_en, itram_rd_en, itram_rd_addr, id_valid, id_inst, id_pc, id_fault
    );

    modport slave (
        output pc_addr, redirect, itram_rd_data, id_ready,
        input  pc_en, itram_rd_en, itram_rd_addr, id_valid, id_inst, id_pc, id_fault
    );

endinterface

// File: rtl/fetch_fifo2.sv
// -----------------------------------------------------------------------------
// fetch_fifo2
// Two-entry FIFO for fetch packets. Push and pop in the same cycle both take
// effect; flush empties it. Stored data is not reset.
// Ports:
//   clk      - clock
//   rst_i    - synchronous active-high reset (empties FIFO)
//   flush_i  - synchronous flush (empties FIFO, overrides push/pop)
//   push_i   - enqueue din_i (ignored when full and not popping)
//   din_i    - packet to enqueue
//   pop_i    - dequeue head (ignored when empty)
//   dout_o   - head packet
//   count_o  - occupancy 0..2
// -----------------------------------------------------------------------------
module fetch_fifo2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != 2'd0);
        // A full FIFO still accepts a push when the head leaves this cycle.
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. Issues one RAM read per cycle that pc_en is high,
// tracks the single read in flight across the RAM's 1-cycle latency, and
// queues completed packets {pc, inst, fault} in a 2-entry FIFO toward decode.
// Misaligned or out-of-range addresses issue no RAM read and yield NOP_INST
// with the fault flag set. redirect flushes everything in the same cycle.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - inst_fetch_if.master: pc_addr/pc_en/redirect, itram_rd_*, id_*
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = CFG_XLEN,
    parameter logic [XLEN-1:0] BOOT_IT_ADDR = CFG_BOOT_IT_ADDR,
    parameter int unsigned     IT_RAM_DEPTH = CFG_IT_RAM_DEPTH,
    parameter logic [31:0]     NOP_INST     = CFG_NOP_INST
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    localparam int unsigned AW    = $clog2(IT_RAM_DEPTH / 4);
    localparam int unsigned PKT_W = XLEN + 33;

    logic            infl_v_q,     infl_v_d;
    logic [XLEN-1:0] infl_pc_q,    infl_pc_d;
    logic            infl_fault_q, infl_fault_d;

    logic            pc_en;
    logic            fault;
    logic            pop;
    logic            push;
    logic [2:0]      occ;
    logic [XLEN:0]   pc_ext;
    logic [XLEN:0]   lo_ext;
    logic [XLEN:0]   hi_ext;
    logic [XLEN-1:0] off;
    logic [1:0]      fifo_count;
    logic [PKT_W-1:0] push_pkt;
    logic [PKT_W-1:0] head_pkt;
    logic            unused_off_bits;

    // Range compare one bit wider than XLEN so the upper bound cannot wrap.
    always_comb begin
        pc_ext = {1'b0, bus.pc_addr};
        lo_ext = {1'b0, BOOT_IT_ADDR};
        hi_ext = lo_ext + (XLEN+1)'(IT_RAM_DEPTH);
        fault  = (bus.pc_addr[1:0] != 2'b00) || (pc_ext < lo_ext) || (pc_ext >= hi_ext);
    end

    // Fetch allowed when the packets still owed (queued + in flight), less
    // the one leaving this cycle, leave room in the 2-entry FIFO.
    always_comb begin
        pop   = bus.id_valid && bus.id_ready;
        occ   = {1'b0, fifo_count} + {2'b00, infl_v_q};
        pc_en = !rst && !bus.redirect && (occ < (3'd2 + {2'b00, pop}));
    end

    assign off               = bus.pc_addr - BOOT_IT_ADDR;
    assign unused_off_bits   = ^{off[XLEN-1:AW+2], off[1:0]};
    assign bus.pc_en         = pc_en ? EN_ON : EN_OFF;
    assign bus.itram_rd_en   = (pc_en && !fault) ? EN_ON : EN_OFF;
    assign bus.itram_rd_addr = off[AW+1:2];

    always_comb begin
        infl_v_d     = pc_en;
        infl_pc_d    = infl_pc_q;
        infl_fault_d = infl_fault_q;
        if (pc_en) begin
            infl_pc_d    = bus.pc_addr;
            infl_fault_d = fault;
        end
    end

    // redirect already forces pc_en low, so it invalidates the slot here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_v_q <= 1'b0;
        end else begin
            infl_v_q <= infl_v_d;
        end
        infl_pc_q    <= infl_pc_d;
        infl_fault_q <= infl_fault_d;
    end

    // RAM data for a read issued before a redirect is dropped here.
    assign push     = infl_v_q && !bus.redirect;
    assign push_pkt = {infl_pc_q, (infl_fault_q ? NOP_INST : bus.itram_rd_data), infl_fault_q};

    fetch_fifo2 #(
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst),
        .flush_i (bus.redirect),
        .push_i  (push),
        .din_i   (push_pkt),
        .pop_i   (pop),
        .dout_o  (head_pkt),
        .count_o (fifo_count)
    );

    assign bus.id_valid = (fifo_count != 2'd0);
    assign bus.id_pc    = head_pkt[PKT_W-1:33];
    assign bus.id_inst  = head_pkt[32:1];
    assign bus.id_fault = head_pkt[0];

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Drives inst_fetch like a PC register plus instruction RAM would. Every
// fetch the DUT accepts is recorded in an expectation queue computed from
// the address rules; a monitor checks the decode side against the queue
// head and the fetch-side strobes against the queue's occupancy.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] BOOT  = 32'h0000_2000;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned WORDS = DEPTH / 4;
    localparam int unsigned AW    = 10;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.XLEN(XLEN), .AW(AW)) bus();

    inst_fetch #(
        .XLEN         (XLEN),
        .BOOT_IT_ADDR (BOOT),
        .IT_RAM_DEPTH (DEPTH),
        .NOP_INST     (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ram_mem [WORDS];
    logic [31:0] tgt;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction RAM: data one cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus.itram_rd_en) bus.itram_rd_data <= ram_mem[bus.itram_rd_addr];
        else                 bus.itram_rd_data <= $urandom();
    end

    function automatic bit is_fault(input logic [31:0] a);
        return ((a % 4) != 0) || (a < BOOT) || (64'(a) >= 64'(BOOT) + 64'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_inst(input logic [31:0] a);
        if (is_fault(a)) return NOP;
        return ram_mem[int'((a - BOOT) / 4)];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: decode-side packet, valid timing and fetch-side strobes.
    always @(negedge clk) begin : monitor
        bit mv;
        bit mpop;
        bit exp_en;
        bit exp_rd;
        mv = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        chk("id_valid", bus.id_valid, mv);
        if (mv) begin
            chk("id_pc", bus.id_pc, q[0].pc);
            chk("id_inst", bus.id_inst, q[0].inst);
            chk("id_fault", bus.id_fault, q[0].fault);
        end
        mpop   = mv && bus.id_ready;
        exp_en = !rst && !bus.redirect && ((int'(q.size()) - int'(mpop)) < 2);
        exp_rd = exp_en && !is_fault(bus.pc_addr);
        chk("pc_en", bus.pc_en, exp_en);
        chk("itram_rd_en", bus.itram_rd_en, exp_rd);
        if (exp_rd) chk("itram_rd_addr", bus.itram_rd_addr, (bus.pc_addr - BOOT) / 4);
        if (mpop) void'(q.pop_front());
    end

    // Scoreboard feed: record each accepted fetch; a flush forgets all owed packets.
    always @(negedge clk) begin : issue
        exp_t e;
        #1;
        if (rst || bus.redirect) begin
            q.delete();
        end else if (bus.pc_en) begin
            e.pc    = bus.pc_addr;
            e.inst  = ref_inst(bus.pc_addr);
            e.fault = is_fault(bus.pc_addr);
            e.cyc   = cyc;
            q.push_back(e);
        end
    end

    // One clock of the PC register: advance on pc_en, load tgt on redirect.
    task automatic tick();
        bit en_s;
        bit rd_s;
        @(negedge clk);
        en_s = bus.pc_en;
        rd_s = bus.redirect;
        @(posedge clk);
        #1;
        if (rd_s)      bus.pc_addr = tgt;
        else if (en_s) bus.pc_addr = bus.pc_addr + 32'd4;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : driver
        for (int i = 0; i < int'(WORDS); i++) ram_mem[i] = $urandom();
        ram_mem[0] = 32'h0000_00A0;
        ram_mem[1] = 32'h0000_00A4;
        ram_mem[2] = 32'h0000_00A8;

        rst          = 1'b1;
        bus.pc_addr  = BOOT;
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        tgt          = BOOT;
        @(posedge clk); #1;
        ticks(3);
        #1;
        chk("rst_pc_en", bus.pc_en, 0);
        chk("rst_rd_en", bus.itram_rd_en, 0);
        chk("rst_id_valid", bus.id_valid, 0);

        // Reset release and first packets.
        rst = 1'b0;
        #1;
        chk("c1_pc_en", bus.pc_en, 1);
        tick(); #1;
        chk("c2_id_valid", bus.id_valid, 0);
        tick(); #1;
        chk("c3_id_valid", bus.id_valid, 1);
        chk("c3_id_pc", bus.id_pc, BOOT);
        chk("c3_id_inst", bus.id_inst, 32'h0000_00A0);
        tick(); #1;
        chk("c4_id_pc", bus.id_pc, BOOT + 32'd4);
        chk("c4_id_inst", bus.id_inst, 32'h0000_00A4);
        tick(); #1;
        chk("c5_id_pc", bus.id_pc, BOOT + 32'd8);
        chk("c5_id_inst", bus.id_inst, 32'h0000_00A8);

        // Backpressure: FIFO fills, fetch stops, head held.
        bus.id_ready = 1'b0;
        ticks(6); #1;
        chk("stall_pc_en", bus.pc_en, 0);
        chk("stall_id_pc", bus.id_pc, BOOT + 32'd8);
        bus.id_ready = 1'b1;
        #1;
        chk("drain_pc_en", bus.pc_en, 1);
        ticks(4);

        // Redirect with a full FIFO.
        bus.id_ready = 1'b0;
        ticks(3);
        bus.redirect = 1'b1;
        tgt          = BOOT + 32'h100;
        #1;
        chk("redir_pc_en", bus.pc_en, 0);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("redir_next_valid", bus.id_valid, 0);
        chk("redir_resume_pc_en", bus.pc_en, 1);
        bus.id_ready = 1'b1;
        tick(); #1;
        chk("redir_r2_valid", bus.id_valid, 0);
        tick(); #1;
        chk("redir_r3_valid", bus.id_valid, 1);
        chk("redir_r3_pc", bus.id_pc, BOOT + 32'h100);
        chk("redir_r3_inst", bus.id_inst, ram_mem[32'h40]);

        // Misaligned and just-past-the-end addresses.
        for (int k = 0; k < 2; k++) begin
            bus.redirect = 1'b1;
            tgt          = (k == 0) ? BOOT + 32'd2 : BOOT + DEPTH;
            tick();
            bus.redirect = 1'b0;
            #1;
            chk("fault_rd_en", bus.itram_rd_en, 0);
            chk("fault_pc_en", bus.pc_en, 1);
            ticks(2); #1;
            chk("fault_id_valid", bus.id_valid, 1);
            chk("fault_id_fault", bus.id_fault, 1);
            chk("fault_id_inst", bus.id_inst, 32'h0000_0013);
            chk("fault_id_pc", bus.id_pc, tgt);
        end

        // Reset with one packet queued and one read in flight.
        bus.redirect = 1'b1;
        tgt          = BOOT + 32'h40;
        tick();
        bus.redirect = 1'b0;
        ticks(3);
        bus.id_ready = 1'b0;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_id_valid", bus.id_valid, 0);
        chk("midrst_pc_en", bus.pc_en, 1);
        bus.id_ready = 1'b1;
        ticks(4);

        // Redirect coinciding with a transfer.
        bus.redirect = 1'b1;
        tgt          = BOOT + 32'h200;
        #1;
        chk("redir_pop_valid", bus.id_valid, 1);
        tick();
        bus.redirect = 1'b0;
        #1;
        chk("redir_pop_next_valid", bus.id_valid, 0);
        ticks(3);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            bus.id_ready = ($urandom_range(0, 9) < 7);
            rst          = ($urandom_range(0, 99) == 0);
            bus.redirect = !rst && ($urandom_range(0, 19) == 0);
            if (bus.redirect) begin
                case ($urandom_range(0, 4))
                    0:       tgt = BOOT + 4 * $urandom_range(0, WORDS - 1);
                    1:       tgt = BOOT + DEPTH - 4 * $urandom_range(1, 3);
                    2:       tgt = BOOT - 4 * $urandom_range(0, 2);
                    3:       tgt = BOOT + $urandom_range(0, DEPTH - 1);
                    default: tgt = BOOT + DEPTH + 4 * $urandom_range(0, 3);
                endcase
            end
            tick();
        end

        rst          = 1'b0;
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        ticks(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
